// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// divider_pkg: op codes, FSM states and helpers shared by the iterative divider.
// Rev 1.0
// ============================================================================
package divider_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  // Widest operand the helper below can handle.
  localparam int unsigned MAX_XLEN = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CALC    = 2'd1,
    ST_FIX     = 2'd2,
    ST_SPECIAL = 2'd3
  } div_state_e;

  function automatic logic [MAX_XLEN-1:0] abs_if_signed(
    input logic [MAX_XLEN-1:0] x,
    input logic                sign_bit,
    input logic                is_signed
  );
    return (is_signed && sign_bit) ? -x : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// div_step: one radix-2 non-restoring iteration on a W-bit partial remainder.
// Rev 1.0
// ============================================================================
module div_step #(
  parameter int W = 33
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_div,
  input  logic         i_bit,
  output logic [W-1:0] o_rem,
  output logic         o_qbit
);

  logic [W-1:0] shifted;

  // A negative partial remainder adds the divisor back instead of subtracting.
  always_comb begin
    shifted = {i_rem[W-2:0], i_bit};
    o_rem   = i_rem[W-1] ? (shifted + i_div) : (shifted - i_div);
    o_qbit  = ~o_rem[W-1];
  end

endmodule
`default_nettype wire

// File: rtl/iter_divider.sv
`default_nettype none
// ============================================================================
// iter_divider: multi-cycle DIV/DIVU/REM/REMU unit with start/done handshake.
// Rev 1.0
// ============================================================================
module iter_divider
  import divider_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int EARLY_OUT = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_A,
  input  logic [XLEN-1:0] i_B,
  input  logic            i_kill,
  output logic            o_ready,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]    rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  div_q, div_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             sel_rem_q, sel_rem_d;
  logic             done_q, done_d;

  logic             in_signed, in_sel_rem, b_zero, in_ovf, in_fast;
  logic [XLEN-1:0]  abs_a, abs_b, fast_res;
  logic [XLEN:0]    step_rem;
  logic             step_qbit;
  logic [XLEN-1:0]  rem_mag, quo_fix, rem_fix, fix_res;

  always_comb begin
    in_signed  = (i_op == DIV_OP_DIV) || (i_op == DIV_OP_REM);
    in_sel_rem = (i_op == DIV_OP_REM) || (i_op == DIV_OP_REMU);
    abs_a      = XLEN'(abs_if_signed(MAX_XLEN'(i_A), i_A[XLEN-1], in_signed));
    abs_b      = XLEN'(abs_if_signed(MAX_XLEN'(i_B), i_B[XLEN-1], in_signed));
    b_zero     = (i_B == '0);
    in_ovf     = in_signed && (i_A == MOST_NEG) && (i_B == '1);
    in_fast    = b_zero || in_ovf || (abs_a < abs_b);
    if (b_zero)      fast_res = in_sel_rem ? i_A : '1;
    else if (in_ovf) fast_res = in_sel_rem ? '0 : i_A;
    else             fast_res = in_sel_rem ? i_A : '0;
  end

  // quo_q starts as |A| and shifts out dividend bits as quotient bits shift in.
  div_step #(.W(XLEN + 1)) u_step (
    .i_rem  (rem_q),
    .i_div  ({1'b0, div_q}),
    .i_bit  (quo_q[XLEN-1]),
    .o_rem  (step_rem),
    .o_qbit (step_qbit)
  );

  always_comb begin
    rem_mag = rem_q[XLEN] ? (rem_q[XLEN-1:0] + div_q) : rem_q[XLEN-1:0];
    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_mag : rem_mag;
    fix_res = sel_rem_q ? rem_fix : quo_fix;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    sel_rem_d = sel_rem_q;
    result_d  = result_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_kill) begin
          sel_rem_d = in_sel_rem;
          if ((EARLY_OUT != 0) && in_fast) begin
            state_d = ST_SPECIAL;
            quo_d   = fast_res;
          end else begin
            state_d   = ST_CALC;
            cnt_d     = CNT_W'(XLEN - 1);
            rem_d     = '0;
            quo_d     = abs_a;
            div_d     = abs_b;
            neg_quo_d = in_signed && (i_A[XLEN-1] ^ i_B[XLEN-1]) && !b_zero;
            neg_rem_d = in_signed && i_A[XLEN-1];
          end
        end
      end
      ST_CALC: begin
        if (i_kill) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = {quo_q[XLEN-2:0], step_qbit};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d = ST_FIX;
            cnt_d   = '0;
          end
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!i_kill) begin
          result_d = fix_res;
          done_d   = 1'b1;
        end
      end
      ST_SPECIAL: begin
        state_d = ST_IDLE;
        if (!i_kill) begin
          result_d = quo_q;
          done_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      sel_rem_q <= sel_rem_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign o_ready  = (state_q == ST_IDLE);
  assign o_busy   = (state_q != ST_IDLE);
  assign o_done   = done_q;
  assign o_result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_iter_divider.sv
`default_nettype none
// ============================================================================
// tb_iter_divider: randomized and directed checks of iter_divider (32 and 64 bit).
// Rev 1.0
// ============================================================================
module tb_iter_divider;
  import divider_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s32, k32, rdy32, bsy32, dn32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, res32;
  logic        s64, k64, rdy64, bsy64, dn64;
  logic [1:0]  op64;
  logic [63:0] a64, b64, res64;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] last_res [2];

  iter_divider #(.XLEN(32), .EARLY_OUT(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(s32), .i_op(op32), .i_A(a32), .i_B(b32),
    .i_kill(k32), .o_ready(rdy32), .o_busy(bsy32), .o_done(dn32), .o_result(res32)
  );

  iter_divider #(.XLEN(64), .EARLY_OUT(0)) u_dut64 (
    .i_clk(clk), .i_rst(rst), .i_start(s64), .i_op(op64), .i_A(a64), .i_B(b64),
    .i_kill(k64), .o_ready(rdy64), .o_busy(bsy64), .o_done(dn64), .o_result(res64)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mask_of(input int xl);
    return (xl == 64) ? '1 : ((64'd1 << xl) - 64'd1);
  endfunction

  // RISC-V division semantics from plain arithmetic on sign-extended values.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [63:0] a_in,
                                            input logic [63:0] b_in, input int xl);
    logic [63:0] m, a, b, q, r;
    longint      sa, sb;
    m  = mask_of(xl);
    a  = a_in & m;
    b  = b_in & m;
    sa = $signed(a[xl-1] ? (a | ~m) : a);
    sb = $signed(b[xl-1] ? (b | ~m) : b);
    if (b == 0) begin
      q = m; r = a;
    end else if (!op[0]) begin
      if (a == (64'd1 << (xl - 1)) && b == m) begin
        q = a; r = 0;
      end else begin
        q = 64'(sa / sb); r = 64'(sa % sb);
      end
    end else begin
      q = a / b; r = a % b;
    end
    return (op[1] ? r : q) & m;
  endfunction

  function automatic bit is_fast(input logic [1:0] op, input logic [63:0] a_in,
                                 input logic [63:0] b_in, input int xl);
    logic [63:0] m, a, b, aa, ab;
    bit sgn;
    m   = mask_of(xl);
    a   = a_in & m;
    b   = b_in & m;
    sgn = !op[0];
    aa  = (sgn && a[xl-1]) ? ((~a + 64'd1) & m) : a;
    ab  = (sgn && b[xl-1]) ? ((~b + 64'd1) & m) : b;
    return (b == 0) || (sgn && a == (64'd1 << (xl - 1)) && b == m) || (aa < ab);
  endfunction

  function automatic logic [63:0] rand_opnd(input int xl);
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0:       v = 64'd0;
      1:       v = '1;
      2:       v = 64'd1 << (xl - 1);
      3:       v = 64'($urandom_range(1, 20));
      4:       v = 64'($urandom_range(0, 1000));
      default: v = {$urandom, $urandom};
    endcase
    return v & mask_of(xl);
  endfunction

  function automatic logic [63:0] res_of(input bit wide);
    return wide ? res64 : {32'd0, res32};
  endfunction
  function automatic logic dn_of(input bit wide);
    return wide ? dn64 : dn32;
  endfunction
  function automatic logic rdy_of(input bit wide);
    return wide ? rdy64 : rdy32;
  endfunction
  function automatic logic bsy_of(input bit wide);
    return wide ? bsy64 : bsy32;
  endfunction

  task automatic drive(input bit wide, input logic s, input logic k, input logic [1:0] op,
                       input logic [63:0] a, input logic [63:0] b);
    if (wide) begin
      s64 = s; k64 = k; op64 = op; a64 = a; b64 = b;
    end else begin
      s32 = s; k32 = k; op32 = op; a32 = a[31:0]; b32 = b[31:0];
    end
  endtask

  task automatic drive_idle(input bit wide, input logic s);
    drive(wide, s, 1'b0, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  // Issue one op, scramble operands after accept, optionally poke i_start while busy.
  task automatic run_op(input bit wide, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input bit chain, input bit poke, input string tag);
    int xl, elat, lat;
    logic [63:0] exp;
    xl   = wide ? 64 : 32;
    exp  = ref_model(op, a, b, xl);
    elat = (!wide && is_fast(op, a, b, xl)) ? 1 : xl + 1;
    if (!chain) @(negedge clk);
    check_val({tag, ".rdy"}, 64'(rdy_of(wide)), 64'd1);
    drive(wide, 1'b1, 1'b0, op, a, b);
    @(negedge clk);
    drive_idle(wide, 1'b0);
    check_val({tag, ".busy"}, 64'(bsy_of(wide)), 64'd1);
    lat = 0;
    while (!dn_of(wide) && lat < 200) begin
      @(negedge clk);
      lat++;
      drive_idle(wide, poke && lat == 4);
    end
    check_val({tag, ".lat"}, 64'(lat), 64'(elat));
    check_val({tag, ".res"}, res_of(wide), exp);
    check_val({tag, ".rdy_done"}, 64'(rdy_of(wide)), 64'd1);
    last_res[wide] = exp;
  endtask

  task automatic kill_op(input bit wide, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input int kill_at, input string tag);
    int xl, dn_cnt;
    xl     = wide ? 64 : 32;
    dn_cnt = 0;
    @(negedge clk);
    drive(wide, 1'b1, 1'b0, op, a, b);
    @(negedge clk);
    drive_idle(wide, 1'b0);
    for (int i = 0; i < kill_at; i++) begin
      @(negedge clk);
      dn_cnt += int'(dn_of(wide));
    end
    drive(wide, 1'b0, 1'b1, op, a, b);
    @(negedge clk);
    drive_idle(wide, 1'b0);
    check_val({tag, ".rdy"}, 64'(rdy_of(wide)), 64'd1);
    check_val({tag, ".res"}, res_of(wide), last_res[wide]);
    dn_cnt += int'(dn_of(wide));
    repeat (xl + 2) begin
      @(negedge clk);
      dn_cnt += int'(dn_of(wide));
    end
    check_val({tag, ".no_done"}, 64'(dn_cnt), 64'd0);
  endtask

  initial begin
    int dn_cnt;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
    last_res[0] = 64'd0;
    last_res[1] = 64'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int w = 0; w < 2; w++) begin
      check_val("reset.rdy", 64'(rdy_of(w[0])), 64'd1);
      check_val("reset.busy", 64'(bsy_of(w[0])), 64'd0);
      check_val("reset.done", 64'(dn_of(w[0])), 64'd0);
      check_val("reset.res", res_of(w[0]), 64'd0);
    end

    run_op(1'b0, DIV_OP_DIVU, 64'd100, 64'd7, 1'b0, 1'b0, "divu_100_7");
    run_op(1'b0, DIV_OP_REMU, 64'd100, 64'd7, 1'b0, 1'b0, "remu_100_7");
    run_op(1'b0, DIV_OP_DIV, 64'hFFFF_FFF9, 64'd2, 1'b0, 1'b0, "div_m7_2");
    run_op(1'b0, DIV_OP_REM, 64'hFFFF_FFF9, 64'd2, 1'b0, 1'b0, "rem_m7_2");
    run_op(1'b0, DIV_OP_REM, 64'd7, 64'hFFFF_FFFE, 1'b0, 1'b0, "rem_7_m2");
    run_op(1'b0, DIV_OP_DIVU, 64'd5, 64'd0, 1'b0, 1'b0, "divu_by0");
    run_op(1'b0, DIV_OP_REM, 64'd5, 64'd0, 1'b0, 1'b0, "rem_by0");
    run_op(1'b0, DIV_OP_DIV, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 1'b0, "div_ovf");
    run_op(1'b0, DIV_OP_REM, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 1'b0, "rem_ovf");
    run_op(1'b0, DIV_OP_REM, 64'hFFFF_FFFD, 64'd9, 1'b0, 1'b0, "rem_small");

    kill_op(1'b0, DIV_OP_DIVU, 64'd1000, 64'd3, 10, "kill_calc");
    run_op(1'b0, DIV_OP_DIVU, 64'd9, 64'd3, 1'b0, 1'b0, "after_kill");
    kill_op(1'b0, DIV_OP_DIV, 64'd1000, 64'd7, 32, "kill_fix");
    kill_op(1'b0, DIV_OP_DIVU, 64'd5, 64'd0, 0, "kill_spec");

    // Start together with kill while idle must not launch anything.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, DIV_OP_DIVU, 64'd1000, 64'd3);
    @(negedge clk);
    drive_idle(1'b0, 1'b0);
    check_val("start_kill.rdy", 64'(rdy32), 64'd1);
    dn_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      dn_cnt += int'(dn32);
    end
    check_val("start_kill.no_done", 64'(dn_cnt), 64'd0);

    run_op(1'b0, DIV_OP_DIVU, 64'd12345, 64'd11, 1'b0, 1'b1, "poke_busy");
    run_op(1'b0, DIV_OP_DIV, 64'hFFFF_0000, 64'd77, 1'b1, 1'b0, "b2b_1");
    run_op(1'b0, DIV_OP_DIVU, 64'd3, 64'd0, 1'b1, 1'b0, "b2b_2");
    run_op(1'b0, DIV_OP_REMU, 64'd999, 64'd10, 1'b1, 1'b0, "b2b_3");

    run_op(1'b1, DIV_OP_DIVU, 64'h8000_0000_0000_0000, 64'd3, 1'b0, 1'b0, "divu64");
    run_op(1'b1, DIV_OP_DIVU, 64'd5, 64'd0, 1'b0, 1'b0, "divu64_by0");
    run_op(1'b1, DIV_OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 1'b0, 1'b0, "rem64_by0");
    run_op(1'b1, DIV_OP_DIV, 64'h8000_0000_0000_0000, '1, 1'b0, 1'b0, "div64_ovf");

    for (int i = 0; i < 40; i++)
      run_op(1'b0, 2'($urandom), rand_opnd(32), rand_opnd(32), (i % 5) == 3, 1'b0, "rnd32");
    for (int i = 0; i < 8; i++)
      run_op(1'b1, 2'($urandom), rand_opnd(64), rand_opnd(64), 1'b0, 1'b0, "rnd64");

    // Reset pulsed mid-calculation on the 64-bit unit.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, DIV_OP_DIVU, 64'd123456789, 64'd7);
    @(negedge clk);
    drive_idle(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int w = 0; w < 2; w++) begin
      check_val("rst_mid.rdy", 64'(rdy_of(w[0])), 64'd1);
      check_val("rst_mid.busy", 64'(bsy_of(w[0])), 64'd0);
      check_val("rst_mid.done", 64'(dn_of(w[0])), 64'd0);
      check_val("rst_mid.res", res_of(w[0]), 64'd0);
    end
    last_res[0] = 64'd0;
    last_res[1] = 64'd0;
    run_op(1'b1, DIV_OP_REMU, 64'd123456789, 64'd7, 1'b0, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
